jk_seq_monitor: RTL
===================

Name: jk_seq_monitor

Overview:
Downstream checker for the 3-bit JK-flip-flop counter (state bits a,b,c). The counter has no reset and powers up in an arbitrary state, so this block acquires lock onto its fixed 8-state sequence, reports the sequence position, counts full periods, and flags and counts illegal transitions. It shares the counter's clk domain and feeds status and debug logic.

Parameters:
LOCK_N, 3, consecutive legal transitions required to declare lock (1..15)
ERR_W, 8, width of saturating error counter
WRAP_W, 16, width of modulo period counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  monitor enable; low forces IDLE on the next edge
a  in  1  counter state bit A (MSB)
b  in  1  counter state bit B
c  in  1  counter state bit C (LSB)
clr_err  in  1  synchronous clear of err and err_cnt
locked  out  1  sequence lock status
idx  out  3  position of the current state in the sequence, valid when locked
wrap  out  1  one-cycle pulse on each 100->000 transition while locked
wrap_cnt  out  WRAP_W  number of completed periods while locked, modulo 2^WRAP_W
err_pulse  out  1  one-cycle pulse on an illegal transition while locked
err  out  1  sticky error flag
err_cnt  out  ERR_W  illegal transitions while locked, saturating

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low. While rst_n=0, every register and output is 0 and the FSM is in IDLE.
- Legal sequence, written as {a,b,c}: 000->101->010->001->111->110->011->100->000.
- idx decode: 000=0, 101=1, 010=2, 001=3, 111=4, 110=5, 011=6, 100=7.
- Pipeline:
  - s1 <= {a,b,c} on every edge; s2 <= s1.
  - v1 and v2 are valid flags for s1 and s2. Both are cleared by reset and by en=0.
  - A transition is checked when v1 and v2 are both 1: legal iff s1 == NEXT(s2).
  - All outputs are registered. An input applied before edge k produces its check result after edge k+1, a latency of 2 edges.
- FSM states: IDLE, ACQ, LOCKED.
  - IDLE: cnt=0 and v flags fill. When v1 and v2 are both set, go to ACQ.
  - ACQ, legal transition: cnt++. When cnt reaches LOCK_N, go to LOCKED and set locked=1.
  - ACQ, illegal transition: cnt=0 and stay in ACQ. Errors are not counted while acquiring.
  - LOCKED, legal transition: idx <= IDX(s1). If s2=100 and s1=000, pulse wrap and increment wrap_cnt, wrapping to 0 past its maximum.
  - LOCKED, illegal transition (this includes a stall, s1==s2):
    - pulse err_pulse and set err=1;
    - err_cnt++, holding at all-ones once saturated;
    - clear locked and cnt, and go to ACQ.
  - Any state with en=0: next state is IDLE, locked=0, v flags cleared. err, err_cnt and wrap_cnt hold; pulses are 0.
- idx holds its last value when not locked. Consumers qualify idx with locked.
- clr_err alone clears err and err_cnt at the next edge.
- clr_err on the same edge as an illegal transition: clear first, then count. Result is err=1, err_cnt=1, err_pulse=1.
- wrap and err_pulse are mutually exclusive by construction.
- Reset asserted mid-operation: outputs drop to 0 immediately, without waiting for clk. After release, lock is re-acquired from IDLE.

Decomposition:
- Package jk_seq_pkg:
  - state enum {IDLE, ACQ, LOCKED};
  - constant SEQ_LEN=8;
  - functions NEXT(state3) and IDX(state3) implementing the tables above.
- Sub-module jk_seq_decode (combinational): inputs s2 and s1; outputs legal, idx, is_wrap. This isolates the tables from the FSM and counter logic.

Test Plan:
1. Reset, en=1, drive the legal sequence starting at 000 from the edge after rst_n release -> locked=1 after exactly 2+LOCK_N edges (fill plus 3 transitions), idx tracks the decode table, err=0.
2. Keep locked for 32 cycles from idx 0 -> wrap pulses 4 times, wrap_cnt=4 at the end, err_cnt=0.
3. While locked at 010, drive 111 instead of 001 -> err_pulse for one cycle, err=1, err_cnt=1, locked=0. Resume the legal sequence from 111 -> relock after 3 legal transitions.
4. ERR_W=2 with 5 separate illegal events, each followed by relock -> err_cnt saturates at 3. Then clr_err together with a 6th error -> err_cnt=1, err=1.
5. Start the counter at an arbitrary state (e.g. 110) -> lock acquired from that point with first locked idx=IDX of the state, no error counted during ACQ. Then drop en for 2 cycles -> locked=0, counters hold, and re-acquire takes 2+LOCK_N edges.
6. Pulse rst_n low between clock edges while locked with err_cnt=2 -> all outputs become 0 asynchronously. After release, behaviour matches scenario 1.

Source files
------------

// File: rtl/jk_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_seq_pkg
// Brief    : Shared types, constants and sequence tables for the JK counter
//            sequence monitor.
// Revision : 1.0 - initial release
// ============================================================================
package jk_seq_pkg;

    // Monitor FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Number of distinct states in one counter period.
    localparam int SEQ_LEN = 8;

    // Successor of a counter state, {a,b,c}, in the fixed JK sequence.
    function automatic logic [2:0] NEXT(input logic [2:0] s);
        logic [2:0] n;
        case (s)
            3'b000:  n = 3'b101;
            3'b101:  n = 3'b010;
            3'b010:  n = 3'b001;
            3'b001:  n = 3'b111;
            3'b111:  n = 3'b110;
            3'b110:  n = 3'b011;
            3'b011:  n = 3'b100;
            default: n = 3'b000;  // 3'b100 wraps to the start
        endcase
        return n;
    endfunction

    // Position of a counter state within the sequence, 000 being position 0.
    function automatic logic [2:0] IDX(input logic [2:0] s);
        logic [2:0] i;
        case (s)
            3'b000:  i = 3'd0;
            3'b101:  i = 3'd1;
            3'b010:  i = 3'd2;
            3'b001:  i = 3'd3;
            3'b111:  i = 3'd4;
            3'b110:  i = 3'd5;
            3'b011:  i = 3'd6;
            default: i = 3'd7;    // 3'b100
        endcase
        return i;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_seq_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : jk_seq_monitor_if
// Brief    : Counter-side inputs and status outputs of the sequence monitor.
//            master = counter/consumer side, slave = monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface jk_seq_monitor_if #(
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 16
);
    logic              en;
    logic              a;
    logic              b;
    logic              c;
    logic              clr_err;
    logic              locked;
    logic [2:0]        idx;
    logic              wrap;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              err_pulse;
    logic              err;
    logic [ERR_W-1:0]  err_cnt;

    modport master (
        output en, a, b, c, clr_err,
        input  locked, idx, wrap, wrap_cnt, err_pulse, err, err_cnt
    );

    modport slave (
        input  en, a, b, c, clr_err,
        output locked, idx, wrap, wrap_cnt, err_pulse, err, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/jk_seq_decode.sv
`default_nettype none
// ============================================================================
// Module   : jk_seq_decode
// Brief    : Combinational transition check. Compares the newer sample s1
//            against the successor of the older sample s2 and decodes the
//            sequence position of s1.
// Revision : 1.0 - initial release
// ============================================================================
module jk_seq_decode
    import jk_seq_pkg::*;
(
    input  logic [2:0] s2,
    input  logic [2:0] s1,
    output logic       legal,
    output logic [2:0] idx,
    output logic       is_wrap
);

    // Table lookups; a stall (s1 == s2) is never legal since NEXT has no fixed point.
    always_comb begin
        legal   = (s1 == NEXT(s2));
        idx     = IDX(s1);
        is_wrap = (s2 == 3'b100) && (s1 == 3'b000);
    end

endmodule
`default_nettype wire

// File: rtl/jk_seq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : jk_seq_monitor
// Brief    : Lock-acquiring checker for the free-running 3-bit JK counter.
//            Two-stage sample pipeline feeds a transition checker; an
//            IDLE/ACQ/LOCKED FSM tracks lock, sequence position, completed
//            periods and illegal transitions.
// Revision : 1.0 - initial release
// ============================================================================
module jk_seq_monitor
    import jk_seq_pkg::*;
#(
    parameter int LOCK_N = 3,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    jk_seq_monitor_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_ACQ    = ACQ;
    localparam logic [1:0] ST_LOCKED = LOCKED;
    localparam logic [3:0] C_LOCK_N  = 4'(LOCK_N);

    // Sample pipeline
    logic [2:0]        r_s1;
    logic [2:0]        r_s2;
    logic              r_v1;
    logic              r_v2;

    // FSM and status registers
    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_locked;
    logic [2:0]        r_idx;
    logic              r_wrap;
    logic [WRAP_W-1:0] r_wrap_cnt;
    logic              r_err_pulse;
    logic              r_err;
    logic [ERR_W-1:0]  r_err_cnt;

    // Decode results and next-state values
    logic              w_legal;
    logic [2:0]        w_idx;
    logic              w_is_wrap;
    logic              w_check;
    logic [3:0]        w_cnt_inc;
    logic [1:0]        w_state_nxt;
    logic [3:0]        w_cnt_nxt;
    logic              w_locked_nxt;
    logic [2:0]        w_idx_nxt;
    logic              w_wrap_nxt;
    logic [WRAP_W-1:0] w_wrap_cnt_nxt;
    logic              w_err_ev;
    logic [ERR_W-1:0]  w_err_base;
    logic [ERR_W-1:0]  w_err_cnt_nxt;
    logic              w_err_nxt;

    jk_seq_decode u_decode (
        .s2      (r_s2),
        .s1      (r_s1),
        .legal   (w_legal),
        .idx     (w_idx),
        .is_wrap (w_is_wrap)
    );

    assign w_check   = r_v1 & r_v2;
    assign w_cnt_inc = r_cnt + 4'd1;

    // Capture the counter state every edge; valid flags restart after enable drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 3'b000;
            r_s2 <= 3'b000;
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_s1 <= {bus.a, bus.b, bus.c};
            r_s2 <= r_s1;
            r_v1 <= bus.en;
            r_v2 <= bus.en & r_v1;
        end
    end

    // Lock FSM: the first checked transition already counts towards lock,
    // so lock is reached 2+LOCK_N edges after samples start flowing.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_locked_nxt   = r_locked;
        w_idx_nxt      = r_idx;
        w_wrap_nxt     = 1'b0;
        w_wrap_cnt_nxt = r_wrap_cnt;
        w_err_ev       = 1'b0;
        if (!bus.en) begin
            w_state_nxt  = ST_IDLE;
            w_cnt_nxt    = 4'd0;
            w_locked_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACQ: begin
                    if (w_check) begin
                        if (!w_legal) begin
                            w_state_nxt = ST_ACQ;
                            w_cnt_nxt   = 4'd0;
                        end else if (w_cnt_inc == C_LOCK_N) begin
                            w_state_nxt  = ST_LOCKED;
                            w_cnt_nxt    = 4'd0;
                            w_locked_nxt = 1'b1;
                            w_idx_nxt    = w_idx;
                        end else begin
                            w_state_nxt = ST_ACQ;
                            w_cnt_nxt   = w_cnt_inc;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_check) begin
                        if (w_legal) begin
                            w_idx_nxt = w_idx;
                            if (w_is_wrap) begin
                                w_wrap_nxt     = 1'b1;
                                w_wrap_cnt_nxt = r_wrap_cnt + WRAP_W'(1);
                            end
                        end else begin
                            w_err_ev     = 1'b1;
                            w_state_nxt  = ST_ACQ;
                            w_cnt_nxt    = 4'd0;
                            w_locked_nxt = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_cnt_nxt    = 4'd0;
                    w_locked_nxt = 1'b0;
                end
            endcase
        end
    end

    // Error bookkeeping: a clear is applied first, then a same-edge error counts on top.
    always_comb begin
        w_err_base    = bus.clr_err ? '0 : r_err_cnt;
        w_err_cnt_nxt = w_err_base;
        if (w_err_ev && !(&w_err_base)) begin
            w_err_cnt_nxt = w_err_base + ERR_W'(1);
        end
        w_err_nxt = w_err_ev | (r_err & ~bus.clr_err);
    end

    // Register FSM state and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_locked    <= 1'b0;
            r_idx       <= 3'd0;
            r_wrap      <= 1'b0;
            r_wrap_cnt  <= '0;
            r_err_pulse <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_locked    <= w_locked_nxt;
            r_idx       <= w_idx_nxt;
            r_wrap      <= w_wrap_nxt;
            r_wrap_cnt  <= w_wrap_cnt_nxt;
            r_err_pulse <= w_err_ev;
            r_err       <= w_err_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
        end
    end

    assign bus.locked    = r_locked;
    assign bus.idx       = r_idx;
    assign bus.wrap      = r_wrap;
    assign bus.wrap_cnt  = r_wrap_cnt;
    assign bus.err_pulse = r_err_pulse;
    assign bus.err       = r_err;
    assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire
